// File: rtl/dff_readout_sequencer.sv
// dff_readout_sequencer: snapshot, settle and chain/bit walk for the DFF error-count serializer.
// Optional 8-bit sync header (8'hA5, LSB first) before the payload when DFF_RO_HEADER_EN is defined.
module dff_readout_sequencer #(
  parameter int NUM_CHAINS = 10,
  parameter int BITS_PER_CHAIN = 12,
  parameter int SETTLE_CYCLES = 2,
  parameter logic [31:0] INTERVAL = 32'd0
) (
  input  logic       data_clk,
  input  logic       reset,
  input  logic       start_req,
  output logic       save_data,
  output logic [3:0] chan_sel,
  output logic [3:0] bit_idx,
  output logic       bit_valid,
  output logic       hdr_active,
  output logic       hdr_bit,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] overrun_cnt
);
  localparam logic [3:0] last_chan = 4'(NUM_CHAINS - 1);
  localparam logic [3:0] last_bit = 4'(BITS_PER_CHAIN - 1);
  localparam logic [3:0] last_settle = 4'(SETTLE_CYCLES - 1);
`ifdef DFF_RO_HEADER_EN
  localparam logic [7:0] hdr_pat = 8'hA5;
  typedef enum logic [2:0] {IDLE, SAVE, SETTLE, HEADER, SHIFT, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, SAVE, SETTLE, SHIFT, DONE} state_t;
  assign hdr_active = 1'b0;
  assign hdr_bit = 1'b0;
`endif
  state_t state;
  logic pending;
  logic [31:0] timer;
  logic [3:0] cnt;
  logic tick;
  logic req;
  assign tick = (INTERVAL != 32'd0) && (timer == INTERVAL - 32'd1);
  assign req = start_req | tick;
  always_ff @(posedge data_clk) begin
    if (!reset) timer <= '0;
    else if (INTERVAL != 32'd0) timer <= tick ? '0 : timer + 32'd1;
  end
  always_ff @(posedge data_clk) begin
    if (!reset) begin
      state <= IDLE;
      pending <= 1'b0;
      cnt <= '0;
      overrun_cnt <= '0;
      save_data <= 1'b0;
      chan_sel <= '0;
      bit_idx <= '0;
      bit_valid <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
`ifdef DFF_RO_HEADER_EN
      hdr_active <= 1'b0;
      hdr_bit <= 1'b0;
`endif
    end else begin
      // one request may wait in pending; any further request while busy is dropped and counted
      if (state != IDLE && req) begin
        if (!pending) pending <= 1'b1;
        else if (overrun_cnt != 8'hff) overrun_cnt <= overrun_cnt + 8'd1;
      end
      case (state)
        IDLE: if (req || pending) begin
          state <= SAVE;
          pending <= 1'b0;
          save_data <= 1'b1;
          busy <= 1'b1;
        end
        SAVE: begin
          state <= SETTLE;
          save_data <= 1'b0;
          cnt <= '0;
        end
        SETTLE: if (cnt == last_settle) begin
          cnt <= '0;
`ifdef DFF_RO_HEADER_EN
          state <= HEADER;
          hdr_active <= 1'b1;
          hdr_bit <= hdr_pat[0];
`else
          state <= SHIFT;
          bit_valid <= 1'b1;
`endif
        end else cnt <= cnt + 4'd1;
`ifdef DFF_RO_HEADER_EN
        HEADER: if (cnt == 4'd7) begin
          state <= SHIFT;
          hdr_active <= 1'b0;
          hdr_bit <= 1'b0;
          bit_valid <= 1'b1;
        end else begin
          cnt <= cnt + 4'd1;
          hdr_bit <= hdr_pat[cnt[2:0] + 3'd1];
        end
`endif
        SHIFT: if (bit_idx == last_bit) begin
          bit_idx <= '0;
          if (chan_sel == last_chan) begin
            state <= DONE;
            chan_sel <= '0;
            bit_valid <= 1'b0;
            frame_done <= 1'b1;
          end else chan_sel <= chan_sel + 4'd1;
        end else bit_idx <= bit_idx + 4'd1;
        DONE: begin
          state <= IDLE;
          frame_done <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
